// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: per-register enables/flushes for load-use,
// taken branches, data-memory wait states and the halt drain, plus stall/err status.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1_index,
    input  logic [4:0]       d_rs2_index,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd_index,
    input  logic             e_wb_en,
    input  logic             e_wb_sel,
    input  logic             e_branch_taken,
    input  logic             e_halt,
    input  logic             m_dm_req,
    input  logic             m_dm_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    // One bit per pipeline register, PC first.
    typedef struct packed {
        logic pc;
        logic fd;
        logic de;
        logic em;
        logic mw;
    } stage_t;

    state_t     state, state_nxt;
    stage_t     en, flush;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] drain_cnt, drain_cnt_nxt;
    logic [8:0] wait_inc;
    logic       mem_stall, load_use, timeout, err_set, stall_inc;

    assign mem_stall = m_dm_req & ~m_dm_ready;
    assign load_use  = e_wb_en & e_wb_sel & (e_rd_index != 5'd0) &
                       ((d_use_rs1 & (d_rs1_index == e_rd_index)) |
                        (d_use_rs2 & (d_rs2_index == e_rd_index)));

    // wait_cnt is zero outside a wait, so the first wait cycle sees wait_inc == 1.
    assign wait_inc  = {1'b0, wait_cnt} + 9'd1;
    assign timeout   = (wait_inc >= 9'(MEM_TIMEOUT));
    assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) & ~en.pc;

    // State and counter registers, updated with the pipeline registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            halted    <= (state_nxt == HALTED);
            mem_err   <= mem_err | err_set;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = '0;
        drain_cnt_nxt = drain_cnt;
        err_set       = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_nxt = wait_inc[7:0];
                    if (timeout) begin
                        state_nxt = HALTED;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                    end
                end else if (e_halt) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    // Drain progress freezes while M waits on memory.
                    wait_cnt_nxt = wait_inc[7:0];
                    if (timeout) begin
                        state_nxt = HALTED;
                        err_set   = 1'b1;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt + 2'd1;
                    if (drain_cnt == 2'd1)
                        state_nxt = HALTED;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Output logic; everything held off while reset is asserted.
    always_comb begin
        en    = '0;
        flush = '0;
        if (rst) begin
            case (state)
                RUN, MEM_WAIT: begin
                    en = '1;
                    if (mem_stall) begin
                        en.pc    = 1'b0;
                        en.fd    = 1'b0;
                        en.de    = 1'b0;
                        en.em    = 1'b0;
                        flush.mw = 1'b1;
                    end else if (e_halt) begin
                        en.pc    = 1'b0;
                        flush.fd = 1'b1;
                        flush.de = 1'b1;
                    end else if (e_branch_taken) begin
                        // A taken branch also kills any load-use dependent in D.
                        flush.fd = 1'b1;
                        flush.de = 1'b1;
                    end else if (load_use) begin
                        en.pc    = 1'b0;
                        en.fd    = 1'b0;
                        flush.de = 1'b1;
                    end
                end
                DRAIN: begin
                    en.em    = ~mem_stall;
                    en.mw    = 1'b1;
                    flush.em = ~mem_stall;
                    flush.mw = mem_stall;
                end
                default: ;
            endcase
        end
    end

    assign pc_en    = en.pc;
    assign fd_en    = en.fd;
    assign de_en    = en.de;
    assign em_en    = en.em;
    assign mw_en    = en.mw;
    assign fd_flush = flush.fd;
    assign de_flush = flush.de;
    assign em_flush = flush.em;
    assign mw_flush = flush.mw;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the sequencer.
module tb_pipe_hazard_ctrl;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    d_rs1_index, d_rs2_index, e_rd_index;
    logic          d_use_rs1, d_use_rs2, e_wb_en, e_wb_sel;
    logic          e_branch_taken, e_halt, m_dm_req, m_dm_ready;
    logic          pc_en, fd_en, de_en, em_en, mw_en;
    logic          fd_flush, de_flush, em_flush, mw_flush;
    logic          halted, mem_err;
    logic [CW-1:0] stall_cnt;
    logic [8:0]    ctrl;

    int checks = 0;
    int errors = 0;

    // Model state: plain counters and flags.
    int m_wait, m_drained, m_stalls;
    bit m_drain, m_halt, m_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rd_index(e_rd_index), .e_wb_en(e_wb_en), .e_wb_sel(e_wb_sel),
        .e_branch_taken(e_branch_taken), .e_halt(e_halt),
        .m_dm_req(m_dm_req), .m_dm_ready(m_dm_ready),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign ctrl = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush};

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_wait = 0; m_drained = 0; m_stalls = 0;
        m_drain = 0; m_halt = 0; m_err = 0;
    endfunction

    // Expected {pc,fd,de,em,mw enables, fd,de,em,mw flushes} for current inputs.
    function automatic logic [8:0] exp_ctrl();
        bit ms, hz;
        ms = m_dm_req && !m_dm_ready;
        hz = e_wb_en && e_wb_sel && (e_rd_index != 0) &&
             ((d_use_rs1 && d_rs1_index == e_rd_index) || (d_use_rs2 && d_rs2_index == e_rd_index));
        if (!rst || m_halt) return 9'b00000_0000;
        if (m_drain)        return ms ? 9'b00001_0001 : 9'b00011_0010;
        if (ms)             return 9'b00001_0001;
        if (e_halt)         return 9'b01111_1100;
        if (e_branch_taken) return 9'b11111_1100;
        if (hz)             return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    function automatic void model_update(logic [8:0] c);
        bit ms;
        if (!rst) begin model_reset(); return; end
        if (m_halt) return;
        ms = m_dm_req && !m_dm_ready;
        if (!m_drain && !c[8] && m_stalls < SAT) m_stalls++;
        if (ms) begin
            m_wait++;
            if (m_wait >= TO) begin m_err = 1; m_halt = 1; m_drain = 0; end
        end else begin
            m_wait = 0;
            if (m_drain) begin
                m_drained++;
                if (m_drained == 2) begin m_halt = 1; m_drain = 0; end
            end else if (e_halt) begin
                m_drain = 1; m_drained = 0;
            end
        end
    endfunction

    task automatic idle();
        d_rs1_index = 0; d_rs2_index = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        e_rd_index = 0; e_wb_en = 0; e_wb_sel = 0; e_branch_taken = 0;
        e_halt = 0; m_dm_req = 0; m_dm_ready = 0;
    endtask

    // Advance through the falling edge; inputs change only just after it.
    task automatic step();
        logic [8:0] c;
        c = exp_ctrl();
        @(negedge clk);
        model_update(c);
        #1;
    endtask

    task automatic reset_dut();
        rst = 0; idle(); model_reset();
        @(negedge clk); #1;
        rst = 1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic use2);
        e_wb_en = 1; e_wb_sel = 1; e_rd_index = rd;
        d_use_rs1 = 1; d_rs1_index = 5'd3; d_use_rs2 = use2; d_rs2_index = 5'd5;
    endtask

    task automatic test_reset();
        rst = 0; model_reset();
        e_branch_taken = 1; e_halt = 1; m_dm_req = 1; m_dm_ready = 0;
        e_wb_en = 1; e_wb_sel = 1; e_rd_index = 1; d_use_rs1 = 1; d_rs1_index = 1;
        d_rs2_index = 0; d_use_rs2 = 0;
        @(posedge clk);
        checks++; if (ctrl !== 9'b0) begin errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 9'b0); end
        checks++; if ({halted, mem_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {halted, mem_err}); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        @(negedge clk); #1;
        idle(); rst = 1;
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_0000) begin errors++; $display("FAIL reset_run got %b exp %b", ctrl, 9'b11111_0000); end
        step();
    endtask

    task automatic test_load_use();
        reset_dut();
        set_load_use(5'd5, 1'b1);
        @(posedge clk);
        checks++; if (ctrl !== 9'b00111_0100) begin errors++; $display("FAIL lu_stall got %b exp %b", ctrl, 9'b00111_0100); end
        step(); idle();
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_0000) begin errors++; $display("FAIL lu_after got %b exp %b", ctrl, 9'b11111_0000); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        step();
    endtask

    task automatic test_no_stall();
        reset_dut();
        set_load_use(5'd0, 1'b1); d_rs1_index = 5'd0;
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_0000) begin errors++; $display("FAIL ns_rd0 got %b exp %b", ctrl, 9'b11111_0000); end
        step();
        set_load_use(5'd5, 1'b0);
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_0000) begin errors++; $display("FAIL ns_nors2 got %b exp %b", ctrl, 9'b11111_0000); end
        step(); idle();
        @(posedge clk);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL ns_stall_cnt got %0d exp 0", stall_cnt); end
        step();
    endtask

    task automatic test_branch_over_load();
        reset_dut();
        set_load_use(5'd5, 1'b1); e_branch_taken = 1;
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_1100) begin errors++; $display("FAIL br_ctrl got %b exp %b", ctrl, 9'b11111_1100); end
        step(); idle();
        @(posedge clk);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL br_stall_cnt got %0d exp 0", stall_cnt); end
        step();
    endtask

    task automatic test_mem_wait();
        reset_dut();
        m_dm_req = 1; m_dm_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            checks++; if (ctrl !== 9'b00001_0001) begin errors++; $display("FAIL mw_wait%0d got %b exp %b", i, ctrl, 9'b00001_0001); end
            step();
        end
        m_dm_ready = 1;
        @(posedge clk);
        checks++; if (ctrl !== 9'b11111_0000) begin errors++; $display("FAIL mw_ready got %b exp %b", ctrl, 9'b11111_0000); end
        step(); idle();
        @(posedge clk);
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL mw_stall_cnt got %0d exp 3", stall_cnt); end
        checks++; if ({halted, mem_err} !== 2'b00) begin errors++; $display("FAIL mw_flags got %b exp 00", {halted, mem_err}); end
        step();
    endtask

    task automatic test_timeout();
        reset_dut();
        m_dm_req = 1; m_dm_ready = 0;
        for (int i = 0; i < TO; i++) begin
            @(posedge clk);
            checks++; if (ctrl !== 9'b00001_0001) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, ctrl, 9'b00001_0001); end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            checks++; if (ctrl !== 9'b0) begin errors++; $display("FAIL to_ctrl%0d got %b exp 0", i, ctrl); end
            checks++; if ({halted, mem_err} !== 2'b11) begin errors++; $display("FAIL to_flags%0d got %b exp 11", i, {halted, mem_err}); end
            step();
        end
        checks++; if (stall_cnt !== 4'(TO)) begin errors++; $display("FAIL to_stall_cnt got %0d exp %0d", stall_cnt, TO); end
    endtask

    task automatic test_halt_drain();
        reset_dut();
        e_halt = 1;
        @(posedge clk);
        checks++; if (ctrl !== 9'b01111_1100) begin errors++; $display("FAIL hd_halt got %b exp %b", ctrl, 9'b01111_1100); end
        step(); idle();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            checks++; if (ctrl !== 9'b00011_0010) begin errors++; $display("FAIL hd_drain%0d got %b exp %b", i, ctrl, 9'b00011_0010); end
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hd_early%0d got %b exp 0", i, halted); end
            step();
        end
        @(posedge clk);
        checks++; if (halted !== 1'b1 || ctrl !== 9'b0) begin errors++; $display("FAIL hd_halted got %b/%b exp 1/0", halted, ctrl); end
        step();
        // Second halt, reset arrives mid-drain.
        reset_dut();
        e_halt = 1;
        step(); idle();
        @(posedge clk);
        checks++; if (ctrl !== 9'b00011_0010) begin errors++; $display("FAIL hr_drain got %b exp %b", ctrl, 9'b00011_0010); end
        @(negedge clk); #1;
        rst = 0; model_reset();
        @(posedge clk);
        checks++; if (halted !== 1'b0 || ctrl !== 9'b0) begin errors++; $display("FAIL hr_inreset got %b/%b exp 0/0", halted, ctrl); end
        @(negedge clk); #1;
        rst = 1;
        @(posedge clk);
        checks++; if (halted !== 1'b0 || ctrl !== 9'b11111_0000) begin errors++; $display("FAIL hr_run got %b/%b exp 0/%b", halted, ctrl, 9'b11111_0000); end
        step();
    endtask

    task automatic test_stall_saturate();
        reset_dut();
        set_load_use(5'd5, 1'b1);
        for (int i = 0; i < SAT + 5; i++) step();
        idle();
        @(posedge clk);
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall_cnt got %0d exp 15", stall_cnt); end
        step();
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            rst = !(($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 7) == 0));
            if (!rst) model_reset();
            d_rs1_index = 5'($urandom_range(0, 3));
            d_rs2_index = 5'($urandom_range(0, 3));
            e_rd_index  = 5'($urandom_range(0, 3));
            d_use_rs1 = 1'($urandom_range(0, 1));
            d_use_rs2 = 1'($urandom_range(0, 1));
            e_wb_en   = 1'($urandom_range(0, 1));
            e_wb_sel  = 1'($urandom_range(0, 1));
            e_branch_taken = ($urandom_range(0, 99) < 20);
            e_halt     = ($urandom_range(0, 99) < 4);
            m_dm_req   = ($urandom_range(0, 99) < 35);
            m_dm_ready = ($urandom_range(0, 99) < 45);
            @(posedge clk);
            checks++; if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", i, ctrl, exp_ctrl()); end
            checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted cyc %0d got %b exp %b", i, halted, m_halt); end
            checks++; if (mem_err !== m_err) begin errors++; $display("FAIL rnd_mem_err cyc %0d got %b exp %b", i, mem_err, m_err); end
            checks++; if (stall_cnt !== 4'(m_stalls)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", i, stall_cnt, m_stalls); end
            step();
        end
        rst = 1;
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_over_load();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_stall_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
